// File: rtl/bcd_tick_counter.sv
// Prescaled multi-digit BCD up/down counter with load, wrap/saturate boundary handling
// and an active-low 7-segment decode with optional leading-zero blanking.
`timescale 1ns/1ps
module bcd_tick_counter #(
    parameter int DIGITS   = 3,
    parameter int TICK_DIV = 50000000,
    parameter int SATURATE = 0,
    parameter int LZ_BLANK = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  KEY0,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [DIGITS*4-1:0]   LOAD_VAL,
    output logic [DIGITS*4-1:0]   BCD,
    output logic [DIGITS*7-1:0]   SEG,
    output logic                  TICK,
    output logic                  TC
);

    localparam int            BW         = DIGITS * 4;
    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic          tick_q, tick_d;
    logic          tc_q, tc_d;

    logic [BW-1:0] bcdInc;
    logic [BW-1:0] bcdDec;
    logic [BW-1:0] loadClamped;
    logic          allNines;
    logic          allZeros;

    function automatic logic [3:0] clampDigit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [6:0] segDecode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Ripple the decimal carry/borrow from digit 0 upward; all-9s/all-0s wrap naturally.
    always_comb begin : incDec
        logic       carry;
        logic       borrow;
        logic [3:0] digit;
        carry       = 1'b1;
        borrow      = 1'b1;
        allNines    = 1'b1;
        allZeros    = 1'b1;
        bcdInc      = '0;
        bcdDec      = '0;
        loadClamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit    = bcd_q[i*4 +: 4];
            allNines = allNines && (digit == 4'd9);
            allZeros = allZeros && (digit == 4'd0);

            if (carry) begin
                if (digit == 4'd9) begin
                    bcdInc[i*4 +: 4] = 4'd0;
                end else begin
                    bcdInc[i*4 +: 4] = digit + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                bcdInc[i*4 +: 4] = digit;
            end

            if (borrow) begin
                if (digit == 4'd0) begin
                    bcdDec[i*4 +: 4] = 4'd9;
                end else begin
                    bcdDec[i*4 +: 4] = digit - 4'd1;
                    borrow           = 1'b0;
                end
            end else begin
                bcdDec[i*4 +: 4] = digit;
            end

            loadClamped[i*4 +: 4] = clampDigit(LOAD_VAL[i*4 +: 4]);
        end
    end

    // LOAD beats a coincident step and ignores EN; TICK/TC default low every cycle.
    always_comb begin
        presc_d = presc_q;
        bcd_d   = bcd_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (LOAD) begin
            presc_d = '0;
            bcd_d   = loadClamped;
        end else if (EN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (UP) begin
                    tc_d = allNines;
                    if (!(SATURATE != 0 && allNines)) begin
                        bcd_d = bcdInc;
                    end
                end else begin
                    tc_d = allZeros;
                    if (!(SATURATE != 0 && allZeros)) begin
                        bcd_d = bcdDec;
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            presc_q <= '0;
            bcd_q   <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            bcd_q   <= bcd_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    // Scan from the most significant digit; blanking stops at the first nonzero digit.
    always_comb begin : segOut
        logic       blankRun;
        logic [3:0] digit;
        blankRun = (LZ_BLANK != 0);
        SEG      = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit    = bcd_q[i*4 +: 4];
            blankRun = blankRun && (digit == 4'd0);
            if (blankRun && i != 0) begin
                SEG[i*7 +: 7] = 7'b1111111;
            end else begin
                SEG[i*7 +: 7] = segDecode(digit);
            end
        end
    end

    assign BCD  = bcd_q;
    assign TICK = tick_q;
    assign TC   = tc_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench: a wrap/no-blank and a saturate/blank counter share one stimulus stream;
// expected step results are queued ahead of each step and popped when TICK appears.
`timescale 1ns/1ps
module tb_bcd_tick_counter;

    typedef struct packed {
        logic [11:0] bcd;
        logic        tc;
    } exp_t;

    logic        clk;
    logic        KEY0;
    logic        EN;
    logic        UP;
    logic        LOAD;
    logic [11:0] LOAD_VAL;

    logic [11:0] bcdW, bcdS;
    logic [20:0] segW, segS;
    logic        tickW, tickS, tcW, tcS;

    exp_t qW[$];
    exp_t qS[$];
    exp_t eW, eS;
    int   checks = 0;
    int   errors = 0;

    bcd_tick_counter #(.DIGITS(3), .TICK_DIV(4), .SATURATE(0), .LZ_BLANK(0)) dutW (
        .CLOCK_50(clk), .KEY0(KEY0), .EN(EN), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .BCD(bcdW), .SEG(segW), .TICK(tickW), .TC(tcW)
    );

    bcd_tick_counter #(.DIGITS(3), .TICK_DIV(4), .SATURATE(1), .LZ_BLANK(1)) dutS (
        .CLOCK_50(clk), .KEY0(KEY0), .EN(EN), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .BCD(bcdS), .SEG(segS), .TICK(tickS), .TC(tcS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic up, input logic load,
                                 input logic [11:0] val, input int cycles);
        EN       = en;
        UP       = up;
        LOAD     = load;
        LOAD_VAL = val;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectStep(input logic [11:0] bW, input logic cW,
                              input logic [11:0] bS, input logic cS);
        qW.push_back('{bcd: bW, tc: cW});
        qS.push_back('{bcd: bS, tc: cS});
    endtask

    // Monitor: every TICK must match the oldest queued step; TC may only rise with TICK.
    always @(negedge clk) begin
        if (tickW) begin
            if (qW.size() == 0) begin
                checkOutput("W unexpected tick", 32'(tickW), 32'd0);
            end else begin
                eW = qW.pop_front();
                checkOutput("W step bcd", 32'(bcdW), 32'(eW.bcd));
                checkOutput("W step tc", 32'(tcW), 32'(eW.tc));
            end
        end else begin
            checkOutput("W tc without tick", 32'(tcW), 32'd0);
        end
        if (tickS) begin
            if (qS.size() == 0) begin
                checkOutput("S unexpected tick", 32'(tickS), 32'd0);
            end else begin
                eS = qS.pop_front();
                checkOutput("S step bcd", 32'(bcdS), 32'(eS.bcd));
                checkOutput("S step tc", 32'(tcS), 32'(eS.tc));
            end
        end else begin
            checkOutput("S tc without tick", 32'(tcS), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        KEY0     = 1'b1;
        EN       = 1'b0;
        UP       = 1'b1;
        LOAD     = 1'b0;
        LOAD_VAL = 12'h000;
        #2 KEY0  = 1'b0;
        applyStimulus(0, 1, 0, 12'h000, 2);
        checkOutput("reset bcdW", 32'(bcdW), 32'h000);
        checkOutput("reset tickW", 32'(tickW), 32'd0);
        checkOutput("reset segW", 32'(segW), 32'({7'b1000000, 7'b1000000, 7'b1000000}));
        checkOutput("reset segS blank", 32'(segS), 32'({7'b1111111, 7'b1111111, 7'b1000000}));

        // First step lands on the 4th enabled edge after reset release.
        KEY0 = 1'b1;
        applyStimulus(1, 1, 0, 12'h000, 3);
        checkOutput("pre-step bcdW", 32'(bcdW), 32'h000);
        expectStep(12'h001, 0, 12'h001, 0);
        applyStimulus(1, 1, 0, 12'h000, 1);
        checkOutput("first step bcdW", 32'(bcdW), 32'h001);
        checkOutput("first step tickW", 32'(tickW), 32'd1);
        checkOutput("first step segW", 32'(segW), 32'({7'b1000000, 7'b1000000, 7'b1111001}));
        expectStep(12'h002, 0, 12'h002, 0);
        expectStep(12'h003, 0, 12'h003, 0);
        applyStimulus(1, 1, 0, 12'h000, 8);
        checkOutput("count bcdW", 32'(bcdW), 32'h003);

        // Up-boundary: wrap vs saturate, then two-digit carry.
        applyStimulus(1, 1, 1, 12'h999, 1);
        checkOutput("load tickW", 32'(tickW), 32'd0);
        checkOutput("load bcdS", 32'(bcdS), 32'h999);
        expectStep(12'h000, 1, 12'h999, 1);
        applyStimulus(1, 1, 0, 12'h000, 4);
        checkOutput("wrap bcdW", 32'(bcdW), 32'h000);
        checkOutput("wrap tcW", 32'(tcW), 32'd1);
        checkOutput("sat bcdS", 32'(bcdS), 32'h999);
        applyStimulus(1, 1, 1, 12'h099, 1);
        expectStep(12'h100, 0, 12'h100, 0);
        applyStimulus(1, 1, 0, 12'h000, 4);
        checkOutput("carry bcdW", 32'(bcdW), 32'h100);

        // Down-boundary from 000, then direction change.
        applyStimulus(1, 0, 1, 12'h000, 1);
        expectStep(12'h999, 1, 12'h000, 1);
        expectStep(12'h998, 0, 12'h000, 1);
        applyStimulus(1, 0, 0, 12'h000, 8);
        checkOutput("down bcdW", 32'(bcdW), 32'h998);
        checkOutput("down hold bcdS", 32'(bcdS), 32'h000);
        expectStep(12'h999, 0, 12'h001, 0);
        applyStimulus(1, 1, 0, 12'h000, 4);
        checkOutput("dir change bcdS", 32'(bcdS), 32'h001);

        // Clamped load, then load coinciding with a step edge.
        applyStimulus(1, 1, 1, 12'hFA3, 1);
        checkOutput("clamp bcdW", 32'(bcdW), 32'h993);
        checkOutput("clamp bcdS", 32'(bcdS), 32'h993);
        applyStimulus(1, 1, 0, 12'h000, 3);
        applyStimulus(1, 1, 1, 12'h123, 1);
        checkOutput("coincident load bcdW", 32'(bcdW), 32'h123);
        checkOutput("coincident load tickW", 32'(tickW), 32'd0);
        checkOutput("coincident load tcW", 32'(tcW), 32'd0);

        // Freeze at prescaler 2 for 10 cycles; resume steps 2 cycles later.
        applyStimulus(1, 1, 0, 12'h000, 2);
        applyStimulus(0, 1, 0, 12'h000, 10);
        checkOutput("freeze bcdW", 32'(bcdW), 32'h123);
        checkOutput("freeze tickW", 32'(tickW), 32'd0);
        applyStimulus(1, 1, 0, 12'h000, 1);
        checkOutput("resume+1 bcdW", 32'(bcdW), 32'h123);
        expectStep(12'h124, 0, 12'h124, 0);
        applyStimulus(1, 1, 0, 12'h000, 1);
        checkOutput("resume+2 bcdW", 32'(bcdW), 32'h124);
        checkOutput("resume+2 tickW", 32'(tickW), 32'd1);

        // Asynchronous reset mid-count, held across a load edge.
        applyStimulus(1, 1, 0, 12'h000, 2);
        #2 KEY0 = 1'b0;
        #1;
        checkOutput("async reset bcdW", 32'(bcdW), 32'h000);
        checkOutput("async reset bcdS", 32'(bcdS), 32'h000);
        applyStimulus(1, 1, 1, 12'h555, 1);
        checkOutput("reset over load bcdW", 32'(bcdW), 32'h000);
        KEY0 = 1'b1;
        applyStimulus(1, 1, 0, 12'h000, 3);
        checkOutput("post-reset pre-step bcdS", 32'(bcdS), 32'h000);
        expectStep(12'h001, 0, 12'h001, 0);
        applyStimulus(1, 1, 0, 12'h000, 1);
        checkOutput("post-reset step bcdS", 32'(bcdS), 32'h001);

        // Leading-zero blanking.
        applyStimulus(0, 1, 1, 12'h007, 1);
        checkOutput("blank 007 segS", 32'(segS), 32'({7'b1111111, 7'b1111111, 7'b1111000}));
        checkOutput("noblank 007 segW", 32'(segW), 32'({7'b1000000, 7'b1000000, 7'b1111000}));
        applyStimulus(0, 1, 1, 12'h0F0, 1);
        checkOutput("clamp 0F0 bcdS", 32'(bcdS), 32'h090);
        checkOutput("blank 090 segS", 32'(segS), 32'({7'b1111111, 7'b0010000, 7'b1000000}));
        applyStimulus(0, 1, 0, 12'h000, 2);

        checkOutput("W queue drained", 32'(qW.size()), 32'd0);
        checkOutput("S queue drained", 32'(qS.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
